// File: rtl/max_if.sv
// Operand/result bundle for the max unit.
// master drives operands; slave is the max unit.
interface max_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             clear;
  logic [WIDTH-1:0] max;
  logic             out_valid;
  logic             y_wins;
  logic [WIDTH-1:0] peak;
  logic             peak_valid;

  modport master (
    output in_valid, x, y, clear,
    input  max, out_valid, y_wins,
    input  peak, peak_valid
  );

  modport slave (
    input  in_valid, x, y, clear,
    output max, out_valid, y_wins,
    output peak, peak_valid
  );
endinterface

// File: rtl/max.sv
// Registered max of two operands plus running peak.
// MAX_SIGNED_CMP_EN selects two's-complement compares.
module max #(
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic reset_,
  max_if.slave bus
);
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] peak_q;
  logic [WIDTH-1:0] peak_d;
  logic             y_gt;
  logic             res_gt_peak;
  logic             ov_q;
  logic             yw_q;
  logic             pv_q;
  logic             pv_d;

`ifdef MAX_SIGNED_CMP_EN
  assign y_gt = $signed(bus.y) > $signed(bus.x);
  assign res_gt_peak = $signed(res) > $signed(peak_q);
`else
  assign y_gt = bus.y > bus.x;
  assign res_gt_peak = res > peak_q;
`endif

  // ties fall to x
  assign res = y_gt ? bus.y : bus.x;

  always_comb begin
    peak_d = peak_q;
    pv_d   = pv_q;
    unique case (1'b1)
      bus.clear && bus.in_valid: begin
        peak_d = res;
        pv_d   = 1'b1;
      end
      bus.clear && !bus.in_valid: begin
        peak_d = '0;
        pv_d   = 1'b0;
      end
      !bus.clear && bus.in_valid
        && (!pv_q || res_gt_peak): begin
        peak_d = res;
        pv_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      max_q  <= '0;
      ov_q   <= 1'b0;
      yw_q   <= 1'b0;
      peak_q <= '0;
      pv_q   <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        max_q <= res;
        yw_q  <= y_gt;
      end
      ov_q   <= bus.in_valid;
      peak_q <= peak_d;
      pv_q   <= pv_d;
    end
  end

  assign bus.max        = max_q;
  assign bus.out_valid  = ov_q;
  assign bus.y_wins     = yw_q;
  assign bus.peak       = peak_q;
  assign bus.peak_valid = pv_q;
endmodule

// File: tb/tb_max.sv
// Bench for max: directed vector table, reset
// corners, and random traffic against a history model.
module tb_max;
  logic clock;
  logic reset_;
  int   checks;
  int   errors;

  max_if #(.WIDTH(8)) bus ();

  max #(.WIDTH(8)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       iv;
    logic       cl;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] emax;
    logic       eov;
    logic       eyw;
    logic [7:0] epk;
    logic       epv;
  } vec_t;

  vec_t tbl[$];

  // model: all results since the last clear
  logic [7:0] hist[$];
  logic [7:0] m_max;
  logic       m_ov;
  logic       m_yw;

  function automatic bit gt(logic [7:0] a, logic [7:0] b);
`ifdef MAX_SIGNED_CMP_EN
    return int'($signed(a)) > int'($signed(b));
`else
    return int'(a) > int'(b);
`endif
  endfunction

  function automatic logic [7:0] hist_peak();
    logic [7:0] p;
    p = hist[0];
    foreach (hist[i]) if (gt(hist[i], p)) p = hist[i];
    return p;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [7:0] emax,
                         logic eov, logic eyw,
                         logic [7:0] epk, logic epv);
    chk({tag, ".max"}, int'(bus.max), int'(emax));
    chk({tag, ".out_valid"}, int'(bus.out_valid), int'(eov));
    chk({tag, ".y_wins"}, int'(bus.y_wins), int'(eyw));
    chk({tag, ".peak"}, int'(bus.peak), int'(epk));
    chk({tag, ".peak_valid"}, int'(bus.peak_valid), int'(epv));
  endtask

  task automatic step(logic iv, logic cl,
                      logic [7:0] x, logic [7:0] y);
    bus.in_valid = iv;
    bus.clear    = cl;
    bus.x        = x;
    bus.y        = y;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    hist.delete();
    m_max = '0;
    m_ov  = 1'b0;
    m_yw  = 1'b0;
  endtask

  task automatic model_step(logic iv, logic cl,
                            logic [7:0] x, logic [7:0] y);
    logic [7:0] r;
    r = gt(y, x) ? y : x;
    if (cl) hist.delete();
    if (iv) begin
      hist.push_back(r);
      m_max = r;
      m_yw  = gt(y, x);
    end
    m_ov = iv;
  endtask

  function automatic vec_t mk(logic iv, logic cl,
      logic [7:0] x, logic [7:0] y, logic [7:0] emax,
      logic eov, logic eyw, logic [7:0] epk, logic epv);
    vec_t v;
    v = '{iv, cl, x, y, emax, eov, eyw, epk, epv};
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset_       = 1'b0;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.x        = '0;
    bus.y        = '0;

    tbl.push_back(mk(1, 0, 10, 5, 10, 1, 0, 10, 1));
    tbl.push_back(mk(1, 0, 5, 10, 10, 1, 1, 10, 1));
    tbl.push_back(mk(1, 0, 10, 10, 10, 1, 0, 10, 1));
    tbl.push_back(mk(1, 1, 255, 254, 255, 1, 0, 255, 1));
    tbl.push_back(mk(1, 0, 254, 255, 255, 1, 1, 255, 1));
`ifdef MAX_SIGNED_CMP_EN
    tbl.push_back(mk(1, 0, 127, 128, 127, 1, 0, 127, 1));
`else
    tbl.push_back(mk(1, 0, 127, 128, 128, 1, 1, 255, 1));
`endif
    tbl.push_back(mk(1, 1, 3, 7, 7, 1, 1, 7, 1));
    tbl.push_back(mk(1, 0, 20, 1, 20, 1, 0, 20, 1));
    tbl.push_back(mk(1, 0, 4, 4, 4, 1, 0, 20, 1));
    tbl.push_back(mk(0, 1, 99, 1, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 200, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 77, 66, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 255, 4, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 9, 9, 1, 1, 9, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 9, 1));

    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_ = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].cl, tbl[i].x, tbl[i].y);
      chk_all($sformatf("vec%0d", i), tbl[i].emax,
              tbl[i].eov, tbl[i].eyw, tbl[i].epk,
              tbl[i].epv);
    end

    // async reset pulse between edges
    #2 reset_ = 1'b0;
    #1 chk_all("midrst", 0, 0, 0, 0, 0);
    #1 reset_ = 1'b1;
    step(1, 0, 7, 3);
    chk_all("postrst", 7, 1, 0, 7, 1);

    model_reset();
    model_step(1, 0, 7, 3);
    for (int n = 0; n < 400; n++) begin
      logic       iv;
      logic       cl;
      logic [7:0] x;
      logic [7:0] y;
      iv = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 9) == 0);
      x  = 8'($urandom);
      y  = ($urandom_range(0, 7) == 0) ? x
                                       : 8'($urandom);
      step(iv, cl, x, y);
      model_step(iv, cl, x, y);
      chk_all($sformatf("rnd%0d", n), m_max, m_ov, m_yw,
              hist.size() > 0 ? hist_peak() : 8'd0,
              hist.size() > 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/max.md
Name: max

Overview:
- Registered unsigned maximum unit: each accepted cycle it compares two WIDTH-bit operands and outputs the larger.
- Also keeps a running peak of all results since reset or clear.
- Sits in datapath post-processing, between operand producers and downstream consumers that accept a valid-qualified result stream.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands x, y valid this cycle; pair accepted on rising edge when high.
- x  input  WIDTH  first operand, unsigned.
- y  input  WIDTH  second operand, unsigned.
- clear  input  1  synchronous clear of peak tracking.
- max  output  WIDTH  registered maximum of last accepted pair.
- out_valid  output  1  max holds a fresh result this cycle.
- y_wins  output  1  1 when y was strictly greater than x in last accepted pair.
- peak  output  WIDTH  largest max value produced since reset/clear.
- peak_valid  output  1  peak holds at least one accepted result.

Behaviour:
- Reset: reset_ low asynchronously forces max=0, out_valid=0, y_wins=0, peak=0, peak_valid=0. Held while low; leaving reset needs no extra cycle.
- Comparison: unsigned, full WIDTH. Result is y if y>x, else x.
  - Ties select x; y_wins=0 on ties.
  - No overflow; result is always one of the inputs, bit-exact.
- Latency: 1 cycle. Pair sampled on edge N (in_valid=1) appears on max with out_valid=1 after edge N.
- Throughput: one pair per cycle, no backpressure, no stall.
- When in_valid=0 at an edge:
  - out_valid goes 0.
  - max and y_wins hold their previous values.
- Peak update on each edge:
  - clear=1 and in_valid=1: peak loads the new result, peak_valid=1 (clear-then-accept; new pair starts fresh tracking).
  - clear=1 and in_valid=0: peak=0, peak_valid=0.
  - clear=0 and in_valid=1: peak loads the new result if peak_valid=0 or result>peak, else holds; peak_valid=1.
  - clear=0 and in_valid=0: hold.
- peak updates in the same cycle as max; it reflects the result currently shown on max.
- Reset asserted mid-stream: any in-flight result is discarded, all outputs return to reset values immediately.
- Inputs containing X/Z are out of scope; the bench only drives known values.

Optional Feature:
- Macro MAX_SIGNED_CMP_EN.
- Defined: x, y, max and peak are interpreted as two's-complement signed for all comparisons, including the peak compare. Ties still select x. Reset values unchanged (0).
- Not defined: unsigned comparison as above.
- Port list identical in both builds.

Test Plan:
- Basic x>y: x=10, y=5, in_valid=1 -> after one edge max=10, y_wins=0, out_valid=1.
- Basic y>x: x=5, y=10 -> max=10, y_wins=1.
- Tie: x=10, y=10 -> max=10, y_wins=0.
- Top-of-range: x=255, y=254 -> max=255; then x=254, y=255 -> max=255, y_wins=1. With MAX_SIGNED_CMP_EN, x=255(-1), y=254(-2) -> max=255; x=127, y=128 -> max=127.
- Peak and clear: pairs (3,7), (20,1), (4,4) -> peak 7, 20, 20. Then clear=1 with in_valid=0 -> peak=0, peak_valid=0. Then clear=1 with (2,9) -> peak=9, peak_valid=1.
- Reset and gaps:
  - in_valid=0 for 3 cycles -> out_valid=0, max holds last value.
  - Pulse reset_ low between edges -> max, peak, out_valid, peak_valid, y_wins read 0 immediately, before the next edge.
